// File: rtl/package_sorter_n.sv
// Package sorter: classifies each arriving weight into one of NUM_GRP groups
// against programmable bounds and keeps saturating per-group and total counts.
module package_sorter_n #(
    parameter int WEIGHT_W = 12,
    parameter int COUNT_W  = 8,
    parameter int NUM_GRP  = 6,
    parameter int GRP_W    = $clog2(NUM_GRP + 1),
    parameter int TOTAL_W  = 16,
    parameter logic [(NUM_GRP-1)*WEIGHT_W-1:0] THRESH_INIT =
        {12'd2000, 12'd1000, 12'd800, 12'd500, 12'd200}
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [WEIGHT_W-1:0]        weight,
    input  logic                       cfg_we,
    input  logic [GRP_W-1:0]           cfg_addr,
    input  logic [WEIGHT_W-1:0]        cfg_data,
    input  logic                       clr_we,
    input  logic [GRP_W-1:0]           clr_grp,
    output logic [GRP_W-1:0]           current_grp,
    output logic [NUM_GRP*COUNT_W-1:0] grp_count,
    output logic [NUM_GRP-1:0]         grp_sat,
    output logic [TOTAL_W-1:0]         total_count,
    output logic                       new_pkg
);

    logic [WEIGHT_W-1:0] thr [NUM_GRP-1];
    logic [COUNT_W-1:0]  cnt [NUM_GRP];
    logic [COUNT_W-1:0]  cnt_nxt [NUM_GRP];
    logic [NUM_GRP-1:0]  sat_nxt;
    logic [GRP_W-1:0]    grp;
    logic                prev_zero;
    logic                arrival;

    // Walk from the top bound down so the smallest matching index wins.
    always_comb begin
        grp = GRP_W'(NUM_GRP);
        for (int i = NUM_GRP - 2; i >= 0; i--) begin
            if (weight <= thr[i]) grp = GRP_W'(i + 1);
        end
        if (weight == '0) grp = '0;
    end

    assign arrival = (weight != '0) && prev_zero;

    // Clear is applied before the increment so a collision ends at 1.
    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) begin
            cnt_nxt[g] = cnt[g];
            sat_nxt[g] = grp_sat[g];
            if (clr_we && clr_grp == GRP_W'(g + 1)) begin
                cnt_nxt[g] = '0;
                sat_nxt[g] = 1'b0;
            end
            if (arrival && grp == GRP_W'(g + 1)) begin
                if (&cnt_nxt[g]) sat_nxt[g] = 1'b1;
                else             cnt_nxt[g] = cnt_nxt[g] + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            for (int i = 0; i < NUM_GRP - 1; i++) begin
                thr[i] <= THRESH_INIT[i*WEIGHT_W +: WEIGHT_W];
            end
            for (int g = 0; g < NUM_GRP; g++) begin
                cnt[g] <= '0;
            end
            grp_sat     <= '0;
            total_count <= '0;
            current_grp <= '0;
            new_pkg     <= 1'b0;
            prev_zero   <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_GRP - 1; i++) begin
                if (cfg_we && cfg_addr == GRP_W'(i)) thr[i] <= cfg_data;
            end
            for (int g = 0; g < NUM_GRP; g++) begin
                cnt[g] <= cnt_nxt[g];
            end
            grp_sat     <= sat_nxt;
            current_grp <= grp;
            new_pkg     <= arrival;
            prev_zero   <= (weight == '0);
            if (arrival) total_count <= total_count + TOTAL_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_flat
        assign grp_count[g*COUNT_W +: COUNT_W] = cnt[g];
    end

endmodule

// File: tb/tb_package_sorter_n.sv
// Directed bench for package_sorter_n: per-step scoreboard of group/pulse plus
// a count model checked at scenario boundaries; a 3-group instance is swept too.
module tb_package_sorter_n;

    logic        CLK = 1'b0;
    logic        reset;
    logic [11:0] weight, cfg_data;
    logic        cfg_we, clr_we;
    logic [2:0]  cfg_addr, clr_grp, current_grp;
    logic [47:0] grp_count;
    logic [5:0]  grp_sat;
    logic [15:0] total_count;
    logic        new_pkg;

    logic [11:0] weight3, cfg_data3;
    logic        cfg_we3, clr_we3;
    logic [1:0]  cfg_addr3, clr_grp3, current_grp3;
    logic [23:0] grp_count3;
    logic [2:0]  grp_sat3;
    logic [15:0] total_count3;
    logic        new_pkg3;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [2:0] grp;
        logic       pkg;
    } exp_t;
    exp_t q[$];

    int exp_cnt [1:6];
    bit exp_sat [1:6];
    int exp_total;

    always #5 CLK = ~CLK;

    package_sorter_n u_dut (
        .CLK(CLK), .reset(reset), .weight(weight),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .clr_we(clr_we), .clr_grp(clr_grp),
        .current_grp(current_grp), .grp_count(grp_count),
        .grp_sat(grp_sat), .total_count(total_count), .new_pkg(new_pkg)
    );

    package_sorter_n #(
        .NUM_GRP(3),
        .THRESH_INIT({12'd50, 12'd10})
    ) u_dut3 (
        .CLK(CLK), .reset(reset), .weight(weight3),
        .cfg_we(cfg_we3), .cfg_addr(cfg_addr3), .cfg_data(cfg_data3),
        .clr_we(clr_we3), .clr_grp(clr_grp3),
        .current_grp(current_grp3), .grp_count(grp_count3),
        .grp_sat(grp_sat3), .total_count(total_count3), .new_pkg(new_pkg3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int g = 1; g <= 6; g++) begin
            exp_cnt[g] = 0;
            exp_sat[g] = 0;
        end
        exp_total = 0;
    endtask

    task automatic step(input logic [11:0] w, input logic [2:0] eg,
                        input bit arr, input logic [2:0] clr);
        exp_t e;
        @(negedge CLK);
        weight  = w;
        clr_we  = (clr != 3'd0);
        clr_grp = clr;
        q.push_back('{grp: eg, pkg: arr});
        if (clr >= 3'd1 && clr <= 3'd6) begin
            exp_cnt[clr] = 0;
            exp_sat[clr] = 0;
        end
        if (arr) begin
            if (exp_cnt[eg] == 255) exp_sat[eg] = 1;
            else                    exp_cnt[eg]++;
            exp_total = (exp_total + 1) % 65536;
        end
        @(posedge CLK);
        #1;
        e = q.pop_front();
        chk("current_grp", 32'(current_grp), 32'(e.grp));
        chk("new_pkg", 32'(new_pkg), 32'(e.pkg));
        cfg_we = 1'b0;
        clr_we = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        for (int g = 1; g <= 6; g++) begin
            chk($sformatf("%s_cnt%0d", tag, g),
                32'(grp_count[(g-1)*8 +: 8]), 32'(exp_cnt[g]));
            chk($sformatf("%s_sat%0d", tag, g),
                32'(grp_sat[g-1]), 32'(exp_sat[g]));
        end
        chk({tag, "_total"}, 32'(total_count), 32'(exp_total));
    endtask

    task automatic step3(input logic [11:0] w, input logic [1:0] eg,
                         input bit arr);
        exp_t e;
        @(negedge CLK);
        weight3 = w;
        q.push_back('{grp: 3'(eg), pkg: arr});
        @(posedge CLK);
        #1;
        e = q.pop_front();
        chk("n3_grp", 32'(current_grp3), 32'(e.grp));
        chk("n3_pkg", 32'(new_pkg3), 32'(e.pkg));
    endtask

    initial begin
        reset = 1'b0;
        weight = '0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        clr_we = 0; clr_grp = '0;
        weight3 = '0; cfg_we3 = 0; cfg_addr3 = '0; cfg_data3 = '0;
        clr_we3 = 0; clr_grp3 = '0;
        model_zero();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_grp", 32'(current_grp), 32'd0);
        chk("rst_pkg", 32'(new_pkg), 32'd0);
        check_counts("rst");
        reset = 1'b1;

        // One package per group with default bounds
        begin
            logic [11:0] ws [7] = '{1, 201, 501, 801, 1001, 2001, 4095};
            logic [2:0]  gs [7] = '{1, 2, 3, 4, 5, 6, 6};
            for (int i = 0; i < 7; i++) begin
                step(ws[i], gs[i], 1, 0);
                step(0, 0, 0, 0);
            end
        end
        check_counts("basic");

        // Inclusive boundaries, then a re-weigh without an empty cycle
        step(200, 1, 1, 0);
        step(0, 0, 0, 0);
        step(500, 2, 1, 0);
        step(501, 3, 0, 0);
        step(0, 0, 0, 0);
        check_counts("bound");

        // Saturation of group 1, then clear it
        step(0, 0, 0, 1);
        for (int i = 0; i < 256; i++) begin
            step(1, 1, 1, 0);
            step(0, 0, 0, 0);
        end
        check_counts("sat");
        step(0, 0, 0, 1);
        check_counts("clr");

        // Threshold write colliding with an arrival uses the old bound
        cfg_we = 1; cfg_addr = 0; cfg_data = 100;
        step(150, 1, 1, 0);
        step(0, 0, 0, 0);
        step(150, 2, 1, 0);
        cfg_we = 1; cfg_addr = 5; cfg_data = 1;
        step(0, 0, 0, 7);
        step(90, 1, 1, 0);
        step(0, 0, 0, 0);
        check_counts("cfg");

        // Clear/arrival collision on group 2, and on different groups
        step(0, 0, 0, 2);
        for (int i = 0; i < 5; i++) begin
            step(300, 2, 1, 0);
            step(0, 0, 0, 0);
        end
        check_counts("pre_coll");
        step(300, 2, 1, 2);
        step(0, 0, 0, 0);
        step(300, 2, 1, 1);
        step(0, 0, 0, 0);
        check_counts("coll");

        // Mid-stream reset; inputs during the reset edge are ignored
        @(negedge CLK);
        reset = 0; weight = 600;
        cfg_we = 1; cfg_addr = 2; cfg_data = 5;
        clr_we = 1; clr_grp = 3;
        @(posedge CLK);
        #1;
        model_zero();
        chk("mrst_grp", 32'(current_grp), 32'd0);
        chk("mrst_pkg", 32'(new_pkg), 32'd0);
        check_counts("mrst");
        reset = 1; cfg_we = 0; clr_we = 0;
        step(600, 3, 1, 0);
        step(0, 0, 0, 0);
        step(150, 1, 1, 0);
        step(0, 0, 0, 0);
        check_counts("post_rst");

        // Three-group instance
        step3(10, 1, 1);
        step3(0, 0, 0);
        step3(11, 2, 1);
        step3(0, 0, 0);
        step3(51, 3, 1);
        step3(0, 0, 0);
        step3(50, 2, 1);
        step3(0, 0, 0);
        chk("n3_cnt1", 32'(grp_count3[7:0]), 32'd1);
        chk("n3_cnt2", 32'(grp_count3[15:8]), 32'd2);
        chk("n3_cnt3", 32'(grp_count3[23:16]), 32'd1);
        chk("n3_sat", 32'(grp_sat3), 32'd0);
        chk("n3_total", 32'(total_count3), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/package_sorter_n.md
# package_sorter_n

Parametrised package-sorting counter for the sorting-line datapath. Each cycle it classifies a sampled package weight into one of `NUM_GRP` weight groups against runtime-programmable upper bounds. It counts each new package once per group, using saturating counters with sticky saturation flags. A wrapping total-package counter runs alongside. It is the generalised successor of the fixed six-group sorter, adding configurable group count, widths and thresholds, per-group clear, and overflow handling.

## Interface
- `WEIGHT_W`, 12: weight width.
- `COUNT_W`, 8: per-group counter width.
- `NUM_GRP`, 6: number of groups (≥2).
- `GRP_W`, `$clog2(NUM_GRP+1)`: group-index width.
- `TOTAL_W`, 16: total-package counter width.
- `THRESH_INIT`, {2000,1000,800,500,200} packed `(NUM_GRP-1)*WEIGHT_W`: reset upper bounds. Bound i occupies slice i; bound 0 is in the LSBs.
- `CLK` input 1: single clock; all logic on posedge.
- `reset` input 1: synchronous, active-low; sampled on `CLK` posedge.
- `weight` input `WEIGHT_W`: package weight; 0 means no package present.
- `cfg_we` input 1: threshold write strobe.
- `cfg_addr` input `GRP_W`: threshold index. Legal range is 0..`NUM_GRP`-2; writes outside that range are ignored.
- `cfg_data` input `WEIGHT_W`: new upper bound.
- `clr_we` input 1: group-counter clear strobe.
- `clr_grp` input `GRP_W`: group to clear, 1..`NUM_GRP`; any other value is ignored.
- `current_grp` output `GRP_W`: group of the sampled weight, or 0 when no package.
- `grp_count` output `NUM_GRP*COUNT_W`: flat counters; group g occupies slice g-1.
- `grp_sat` output `NUM_GRP`: sticky saturation flags; bit g-1 belongs to group g.
- `total_count` output `TOTAL_W`: packages seen, modulo 2^`TOTAL_W`.
- `new_pkg` output 1: one-cycle pulse on each counted arrival.

## Operation
- **Classification** (combinational on `weight`, using the registered thresholds `thr[0..NUM_GRP-2]`):
  - group = 1 + the smallest i with `weight` ≤ `thr[i]`.
  - If no bound matches, group = `NUM_GRP`.
  - If `weight` == 0, group = 0.
  - Non-monotonic bounds are legal; the smallest-index rule still applies.
- **Arrival detection:**
  - Register `prev_zero` holds (`weight` == 0) from the previous cycle.
  - An arrival is `weight` ≠ 0 while `prev_zero` = 1.
  - A weight that changes while staying nonzero is not a new package: `current_grp` follows the new weight, but no counter moves.
- **On an arrival:**
  - Increment the counter of the classified group. At 2^`COUNT_W`-1 the counter holds its value and sets the group's `grp_sat` bit.
  - `total_count` increments and wraps.
  - `new_pkg` is 1 for that cycle.
- **Threshold write:** `cfg_we` writes `thr[cfg_addr]` = `cfg_data`. The new bound takes effect from the next cycle.
- **Group clear:** `clr_we` zeroes the selected counter and its `grp_sat` bit.
- **Simultaneous events:**
  - Clear and arrival on the same group in one cycle: clear applies first, then the increment, so the counter ends at 1 and `grp_sat` at 0.
  - Clear on one group, arrival on another: both take effect independently.
  - Threshold write in the same cycle as an arrival: classification uses the old bound.
- **Reset (`reset` = 0 at a posedge), including mid-operation:**
  - All counters and `grp_sat` clear to 0.
  - `total_count` = 0, `current_grp` = 0, `new_pkg` = 0.
  - `thr` reloads from `THRESH_INIT`.
  - `prev_zero` = 1.
  - `weight`, `cfg_*` and `clr_*` are ignored during that cycle.
  - A nonzero weight held across reset release counts on the first cycle after release.

## Timing
- **Single-cycle latency:** inputs sampled at posedge N become visible on `current_grp`, `grp_count`, `grp_sat`, `total_count` and `new_pkg` immediately after posedge N. All outputs are registered.
- **Back-to-back packages:** require at least one intervening cycle with `weight` == 0. Consequently the maximum count rate is one package per two cycles.
- **No handshake:** no backpressure; all strobes are single-cycle and level-sampled.

## Test plan
- **Default thresholds, one package per group:** after reset, present weights 1, 201, 501, 801, 1001, 2001, 4095, each held one cycle and separated by one cycle of 0.
  - Each step: `current_grp` = 1, 2, 3, 4, 5, 6, 6.
  - Final counts {1,1,1,1,1,2}; `total_count` = 7; `new_pkg` pulses 7 times.
- **Boundaries and re-weigh:**
  - 200 → group 1; 500 → group 2.
  - Then hold 500 → 501 without a zero: `current_grp` goes 2→3; group-2 count stays 1; group 3 stays 0; `total_count` unchanged.
- **Saturation** (`COUNT_W` = 8): 256 arrivals of weight 1.
  - Group-1 count = 255, `grp_sat[0]` = 1, `total_count` = 256.
  - Then `clr_we`, `clr_grp` = 1: count = 0, `grp_sat[0]` = 0.
- **Runtime threshold:**
  - Write `cfg_addr` = 0, `cfg_data` = 100 in the same cycle as an arrival of weight 150: the package counts in group 1.
  - Next arrival of 150: it counts in group 2.
- **Clear/arrival collision:** group 2 count = 5; arrival of weight 300 in the same cycle as a clear of group 2 → count = 1.
- **Reset mid-stream:**
  - With nonzero counts, drive `reset` = 0 for one edge: all outputs 0 and thresholds back to defaults.
  - Weight 600 held across release: it counts in group 3 on the first post-reset edge.
- **Parameter sweep:** repeat the first scenario with `NUM_GRP` = 3 and `THRESH_INIT` = {50,10}. Weights 10, 11, 51 → groups 1, 2, 3.
